pic_tmr0_wdt: RTL and testbench

Parametrised Timer0 / prescaler / watchdog block for the next-generation PIC16F5x-class core. It replaces the external tmr0_inc/wdtmr stimulus with an in-core implementation. It consumes the OPTION register and the decoder strobes (TMR0 write, CLRWDT, SLEEP). It produces the TMR0 value for the register file, the overflow pulse, the WDT timeout pulse and the TO/PD status bits.

---
 rtl/pic_tmr_pkg.sv | 20 ++
 rtl/pic_sync_edge.sv | 40 ++++
 rtl/pic_tmr0_wdt.sv | 148 ++++++++++++++
 tb/tb_pic_tmr0_wdt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_tmr_pkg.sv
// pic_tmr_pkg
//   Shared constants for the Timer0 / prescaler / watchdog block.
//   OPTION register bit positions and a helper that builds the
//   prescaler compare mask for a given number of low-order bits.
package pic_tmr_pkg;

  localparam int T0CS_BIT = 5;
  localparam int T0SE_BIT = 4;
  localparam int PSA_BIT  = 3;
  localparam int PS_LSB   = 0;
  localparam int PS_MSB   = 2;

  // Mask with the low 'n' bits set, n in 0..8.
  function automatic logic [7:0] ones_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// pic_sync_edge
//   Two-flop synchroniser for an asynchronous pin followed by an edge
//   register. evt is a one-cycle pulse for the selected pin edge.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   pin      asynchronous input pin
//   fall_sel 0 = rising edge, 1 = falling edge
//   evt      edge event, valid in the cycle after the second sync flop
module pic_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic fall_sel,
  output logic evt
);

  logic sync_p0;
  logic sync_p1;
  logic edge_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      edge_p2 <= 1'b0;
    end else begin
      // stage p0: capture asynchronous pin
      sync_p0 <= pin;
      // stage p1: metastability settle
      sync_p1 <= sync_p0;
      // stage p2: previous synchronised level for edge compare
      edge_p2 <= sync_p1;
    end
  end

  assign evt = fall_sel ? (~sync_p1 &  edge_p2)
                        : ( sync_p1 & ~edge_p2);

endmodule

// File: rtl/pic_tmr0_wdt.sv
// pic_tmr0_wdt
//   Timer0, shared prescaler and watchdog for a PIC16F5x-class core.
// Ports:
//   clk          instruction-cycle clock
//   rst          synchronous active-high reset
//   option       OPTION register: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS
//   t0cki        asynchronous external Timer0 clock pin
//   tmr_wr       TMR0 write strobe, tmr_wdata is the value to load
//   clrwdt       CLRWDT instruction strobe
//   sleep        SLEEP instruction strobe
//   wdt_en       watchdog enable fuse
//   tmr_q        current TMR0 value
//   tmr_ovf      one-cycle pulse on TMR0 wrap to zero
//   wdt_timeout  one-cycle pulse on watchdog expiry
//   to_n, pd_n   active-low time-out / power-down status bits
module pic_tmr0_wdt
  import pic_tmr_pkg::*;
#(
  parameter int TMR_W = 8,
  parameter int PS_W  = 8,
  parameter int WDT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       option,
  input  logic             t0cki,
  input  logic             tmr_wr,
  input  logic [TMR_W-1:0] tmr_wdata,
  input  logic             clrwdt,
  input  logic             sleep,
  input  logic             wdt_en,
  output logic [TMR_W-1:0] tmr_q,
  output logic             tmr_ovf,
  output logic             wdt_timeout,
  output logic             to_n,
  output logic             pd_n
);

  logic             t0cs;
  logic             t0se;
  logic             psa;
  logic [2:0]       ps_sel;
  logic             unused_option_hi;

  logic             ext_evt;
  logic [PS_W-1:0]  ps_q;
  logic [WDT_W-1:0] wdt_q;
  logic [1:0]       inh_q;
  logic             asleep_q;
  logic             psa_q;

  logic             src_evt;
  logic [7:0]       ps_mask;
  logic             ps_full;
  logic             wdt_wrap;
  logic             wdt_clr;
  logic             tmr_tick;
  logic             ps_inc;
  logic             ps_clr;
  logic             timeout;

  assign t0cs             = option[T0CS_BIT];
  assign t0se             = option[T0SE_BIT];
  assign psa              = option[PSA_BIT];
  assign ps_sel           = option[PS_MSB:PS_LSB];
  assign unused_option_hi = &{1'b0, option[7:6]};

  pic_sync_edge u_t0cki_sync (
    .clk      (clk),
    .rst      (rst),
    .pin      (t0cki),
    .fall_sel (t0se),
    .evt      (ext_evt)
  );

  always_comb begin
    src_evt  = t0cs ? ext_evt : ~asleep_q;
    // Timer0 sees 2^(PS+1), the watchdog sees 2^PS.
    ps_mask  = ones_mask(psa ? {1'b0, ps_sel} : ({1'b0, ps_sel} + 4'd1));
    ps_full  = ((ps_q[7:0] & ps_mask) == ps_mask);
    wdt_wrap = wdt_en & (&wdt_q);
    wdt_clr  = clrwdt | sleep;
    tmr_tick = src_evt & (psa | ps_full) & (inh_q == 2'd0);
    ps_inc   = psa ? wdt_wrap : src_evt;
    ps_clr   = (psa != psa_q) | (tmr_wr & ~psa) | (wdt_clr & psa);
    timeout  = wdt_wrap & ~wdt_clr & (~psa | ps_full);
  end

  // Previous PSA value, used only to detect a prescaler reassignment.
  always_ff @(posedge clk) begin
    psa_q <= psa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q       <= '0;
      ps_q        <= '0;
      wdt_q       <= '0;
      inh_q       <= 2'd0;
      asleep_q    <= 1'b0;
      tmr_ovf     <= 1'b0;
      wdt_timeout <= 1'b0;
      to_n        <= 1'b1;
      pd_n        <= 1'b1;
    end else begin
      if (ps_clr) begin
        ps_q <= '0;
      end else if (ps_inc) begin
        ps_q <= ps_q + PS_W'(1);
      end

      // A write blocks the next two ticks, matching the two-cycle
      // synchronisation delay of the original core.
      if (tmr_wr) begin
        tmr_q <= tmr_wdata;
        inh_q <= 2'd2;
      end else begin
        if (tmr_tick) begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
        if (inh_q != 2'd0) begin
          inh_q <= inh_q - 2'd1;
        end
      end
      tmr_ovf <= ~tmr_wr & tmr_tick & (&tmr_q);

      if (!wdt_en || wdt_clr) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_q + WDT_W'(1);
      end
      wdt_timeout <= timeout;

      if (sleep) begin
        to_n     <= 1'b1;
        pd_n     <= 1'b0;
        asleep_q <= 1'b1;
      end else if (clrwdt) begin
        to_n <= 1'b1;
        pd_n <= 1'b1;
      end else if (timeout) begin
        to_n     <= 1'b0;
        asleep_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pic_tmr0_wdt.sv
// tb_pic_tmr0_wdt
//   Self-checking bench for pic_tmr0_wdt: vector table, hand-written
//   corner sequences and a randomized run, all shadowed by a behavioural
//   model that tracks counters as plain integers.
module tb_pic_tmr0_wdt;

  localparam int TMR_W = 8;
  localparam int PS_W  = 8;
  localparam int WDT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       option = 8'h08;
  logic             t0cki = 1'b0;
  logic             tmr_wr = 1'b0;
  logic [TMR_W-1:0] tmr_wdata = '0;
  logic             clrwdt = 1'b0;
  logic             sleep = 1'b0;
  logic             wdt_en = 1'b0;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_ovf;
  logic             wdt_timeout;
  logic             to_n;
  logic             pd_n;

  always #5 clk = ~clk;

  pic_tmr0_wdt #(.TMR_W(TMR_W), .PS_W(PS_W), .WDT_W(WDT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .option      (option),
    .t0cki       (t0cki),
    .tmr_wr      (tmr_wr),
    .tmr_wdata   (tmr_wdata),
    .clrwdt      (clrwdt),
    .sleep       (sleep),
    .wdt_en      (wdt_en),
    .tmr_q       (tmr_q),
    .tmr_ovf     (tmr_ovf),
    .wdt_timeout (wdt_timeout),
    .to_n        (to_n),
    .pd_n        (pd_n)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_tmr, m_ps, m_wdt, m_inh;
  bit m_asleep, m_ton, m_pdn, m_ovf, m_to, m_psa_prev;
  bit h0, h1, h2;   // pin sampled 1, 2 and 3 edges ago

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit psa, ext, evt, wrap, clr, full, tick, tmo, pinc;
    int n;
    psa = option[3];
    if (rst) begin
      m_tmr = 0; m_ps = 0; m_wdt = 0; m_inh = 0;
      m_asleep = 0; m_ton = 1; m_pdn = 1; m_ovf = 0; m_to = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      ext  = option[4] ? (!h1 && h2) : (h1 && !h2);
      evt  = option[5] ? ext : !m_asleep;
      wrap = wdt_en && (m_wdt == (1 << WDT_W) - 1);
      clr  = clrwdt || sleep;
      n    = psa ? int'(option[2:0]) : int'(option[2:0]) + 1;
      full = (m_ps % (1 << n)) == ((1 << n) - 1);
      tick = evt && (psa || full) && (m_inh == 0);
      tmo  = wrap && !clr && (!psa || full);
      pinc = psa ? wrap : evt;

      m_ovf = !tmr_wr && tick && (m_tmr == 255);
      if (tmr_wr) begin
        m_tmr = int'(tmr_wdata);
        m_inh = 2;
      end else begin
        if (tick) m_tmr = (m_tmr + 1) % 256;
        if (m_inh > 0) m_inh--;
      end

      if ((psa != m_psa_prev) || (tmr_wr && !psa) || (clr && psa)) m_ps = 0;
      else if (pinc) m_ps = (m_ps + 1) % 256;

      m_wdt = (!wdt_en || clr) ? 0 : (m_wdt + 1) % (1 << WDT_W);
      m_to  = tmo;

      if (sleep) begin
        m_ton = 1; m_pdn = 0; m_asleep = 1;
      end else if (clrwdt) begin
        m_ton = 1; m_pdn = 1;
      end else if (tmo) begin
        m_ton = 0; m_asleep = 0;
      end
      h2 = h1; h1 = h0; h0 = t0cki;
    end
    m_psa_prev = psa;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", {20'd0, tmr_q, tmr_ovf, wdt_timeout, to_n, pd_n},
                   {20'd0, 8'(m_tmr), m_ovf, m_to, m_ton, m_pdn});
  endtask

  task automatic do_reset(input logic [7:0] opt, input logic en);
    rst = 1'b1; option = opt; wdt_en = en;
    tmr_wr = 1'b0; clrwdt = 1'b0; sleep = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] opt;
    bit         wr;
    logic [7:0] wd;
    logic [7:0] e_tmr;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int pulses;

    // Write-inhibit at 1:1, then 1:2 wrap with overflow pulse.
    tbl[0]  = '{1, 8'h08, 0, 8'h00, 8'h00, 0};
    tbl[1]  = '{1, 8'h08, 0, 8'h00, 8'h00, 0};
    tbl[2]  = '{0, 8'h08, 1, 8'h10, 8'h10, 0};
    tbl[3]  = '{0, 8'h08, 0, 8'h00, 8'h10, 0};
    tbl[4]  = '{0, 8'h08, 0, 8'h00, 8'h10, 0};
    tbl[5]  = '{0, 8'h08, 0, 8'h00, 8'h11, 0};
    tbl[6]  = '{0, 8'h08, 0, 8'h00, 8'h12, 0};
    tbl[7]  = '{0, 8'h00, 1, 8'hFE, 8'hFE, 0};
    tbl[8]  = '{0, 8'h00, 0, 8'h00, 8'hFE, 0};
    tbl[9]  = '{0, 8'h00, 0, 8'h00, 8'hFE, 0};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 8'hFE, 0};
    tbl[11] = '{0, 8'h00, 0, 8'h00, 8'hFF, 0};
    tbl[12] = '{0, 8'h00, 0, 8'h00, 8'hFF, 0};
    tbl[13] = '{0, 8'h00, 0, 8'h00, 8'h00, 1};
    tbl[14] = '{0, 8'h00, 0, 8'h00, 8'h00, 0};
    tbl[15] = '{0, 8'h00, 0, 8'h00, 8'h01, 0};

    wdt_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; option = tbl[i].opt;
      tmr_wr = tbl[i].wr; tmr_wdata = tbl[i].wd;
      step();
      check($sformatf("vec%0d", i), {20'd0, tmr_q, tmr_ovf, wdt_timeout, to_n, pd_n},
            {20'd0, tbl[i].e_tmr, tbl[i].e_ovf, 1'b0, 1'b1, 1'b1});
    end
    tmr_wr = 1'b0;

    // External clock, falling edge, latency and 1:2 ratio.
    t0cki = 1'b1;
    do_reset(8'h38, 1'b0);
    repeat (4) step();
    check("t0_rise_ignored", tmr_q, 8'h00);
    t0cki = 1'b0;
    step(); step();
    check("t0_lat2", tmr_q, 8'h00);
    step();
    check("t0_lat3", tmr_q, 8'h01);
    t0cki = 1'b1;
    repeat (4) step();
    check("t0_rise", tmr_q, 8'h01);
    option = 8'h30;
    for (int e = 0; e < 4; e++) begin
      t0cki = 1'b0; repeat (4) step();
      t0cki = 1'b1; repeat (4) step();
    end
    check("t0_div2", tmr_q, 8'h03);

    // Watchdog 16-cycle base through 1:4 prescaler.
    do_reset(8'h0A, 1'b1);
    pulses = 0;
    for (int c = 0; c < 63; c++) begin
      step();
      pulses += int'(wdt_timeout);
    end
    check("wdt_early", pulses, 0);
    step();
    check("wdt_64", wdt_timeout, 1);
    check("wdt_to_n", to_n, 0);
    step();
    check("wdt_one_cycle", wdt_timeout, 0);

    do_reset(8'h0A, 1'b1);
    repeat (62) step();
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    pulses = 0;
    for (int c = 0; c < 63; c++) begin
      step();
      pulses += int'(wdt_timeout);
    end
    check("clr_no_pulse", pulses, 0);
    check("clr_to_n", to_n, 1);
    step();
    check("wdt_after_clr", wdt_timeout, 1);

    // Sleep freezes internal-clock TMR0, WDT timeout wakes it.
    do_reset(8'h08, 1'b1);
    repeat (3) step();
    check("pre_sleep", tmr_q, 8'h03);
    sleep = 1'b1;
    step();
    sleep = 1'b0;
    check("slp_pd_n", pd_n, 0);
    check("slp_to_n", to_n, 1);
    repeat (15) step();
    check("slp_frozen", tmr_q, 8'h04);
    step();
    check("wake_pulse", {wdt_timeout, to_n, pd_n}, 3'b100);
    check("wake_tmr", tmr_q, 8'h04);
    step();
    check("wake_run1", tmr_q, 8'h05);
    step();
    check("wake_run2", tmr_q, 8'h06);

    // Reset mid-count with a live prescaler and to_n low.
    do_reset(8'h00, 1'b1);
    repeat (16) step();
    check("wdt_direct", {wdt_timeout, to_n}, 2'b10);
    tmr_wr = 1'b1; tmr_wdata = 8'h5A;
    step();
    tmr_wr = 1'b0;
    repeat (3) step();
    check("pre_rst", tmr_q, 8'h5A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_state", {20'd0, tmr_q, tmr_ovf, wdt_timeout, to_n, pd_n},
          {20'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
    step();
    check("rst_ps_clear", tmr_q, 8'h00);
    step();
    check("rst_resume", tmr_q, 8'h01);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) option = 8'($urandom);
      if ($urandom_range(0, 2) == 0) t0cki = ~t0cki;
      tmr_wr    = ($urandom_range(0, 19) == 0);
      tmr_wdata = 8'($urandom);
      clrwdt    = ($urandom_range(0, 59) == 0);
      sleep     = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 199) == 0) wdt_en = ~wdt_en;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
